// File: rtl/bsc_ompss_axis_packet_arbiter.sv
// bsc_ompss_axis_packet_arbiter: packet-level round-robin merge of N_PORTS 64-bit AXI-Stream sources onto one tid-tagged master stream (S_AXIS_* per-port in, M_AXIS_* merged out, grant_onehot/busy status)
module bsc_ompss_axis_packet_arbiter #(
  parameter int N_PORTS = 4,
  parameter int ID_WIDTH = 4,
  parameter int ID_BASE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [64*N_PORTS-1:0]   S_AXIS_tdata,
  input  logic [2*N_PORTS-1:0]    S_AXIS_tdest,
  input  logic [N_PORTS-1:0]      S_AXIS_tlast,
  input  logic [N_PORTS-1:0]      S_AXIS_tvalid,
  output logic [N_PORTS-1:0]      S_AXIS_tready,
  output logic [63:0]             M_AXIS_tdata,
  output logic [1:0]              M_AXIS_tdest,
  output logic [ID_WIDTH-1:0]     M_AXIS_tid,
  output logic                    M_AXIS_tlast,
  output logic                    M_AXIS_tvalid,
  input  logic                    M_AXIS_tready,
  output logic [N_PORTS-1:0]      grant_onehot,
  output logic                    busy
);
  localparam int IW = $clog2(N_PORTS);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state, state_d;
  logic [IW-1:0] grant_idx, grant_idx_d, last_idx, last_idx_d, win, j;
  logic [N_PORTS-1:0] grant_d;
  logic found, fire;
  always_comb begin
    found = 1'b0;
    win = last_idx;
    j = last_idx;
    for (int i = 1; i <= N_PORTS; i++) begin
      j = IW'((int'(last_idx) + i) % N_PORTS);
      if (!found && S_AXIS_tvalid[j]) begin
        found = 1'b1;
        win = j;
      end
    end
  end
  always_comb begin
    state_d = state;
    grant_idx_d = grant_idx;
    grant_d = grant_onehot;
    last_idx_d = last_idx;
    M_AXIS_tdata = '0;
    M_AXIS_tdest = '0;
    M_AXIS_tid = '0;
    M_AXIS_tlast = 1'b0;
    M_AXIS_tvalid = 1'b0;
    S_AXIS_tready = '0;
    fire = 1'b0;
    if (state == IDLE) begin
      if (found) begin
        state_d = PKT;
        grant_idx_d = win;
        grant_d = N_PORTS'(1) << win;
      end
    end else begin
      M_AXIS_tdata = 64'(S_AXIS_tdata >> (64 * int'(grant_idx)));
      M_AXIS_tdest = 2'(S_AXIS_tdest >> (2 * int'(grant_idx)));
      M_AXIS_tid = ID_WIDTH'(ID_BASE + int'(grant_idx));
      M_AXIS_tlast = S_AXIS_tlast[grant_idx];
      // rst blocks the handshake on both sides so a packet cut by reset loses no acknowledged beat
      M_AXIS_tvalid = S_AXIS_tvalid[grant_idx] & ~rst;
      S_AXIS_tready[grant_idx] = M_AXIS_tready & ~rst;
      fire = S_AXIS_tvalid[grant_idx] & M_AXIS_tready & ~rst;
      if (fire && S_AXIS_tlast[grant_idx]) begin
        state_d = IDLE;
        grant_d = '0;
        last_idx_d = grant_idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_idx <= '0;
      grant_onehot <= '0;
      last_idx <= IW'(N_PORTS - 1);
    end else begin
      state <= state_d;
      grant_idx <= grant_idx_d;
      grant_onehot <= grant_d;
      last_idx <= last_idx_d;
    end
  end
  assign busy = state == PKT;
endmodule

// File: tb/tb_bsc_ompss_axis_packet_arbiter.sv
// tb_bsc_ompss_axis_packet_arbiter: directed and randomized checks of the packet arbiter against a packet-level model
module tb_bsc_ompss_axis_packet_arbiter;
  localparam int N = 4;
  localparam int IDW = 4;
  localparam int IDB = 0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [64*N-1:0] s_tdata = '0;
  logic [2*N-1:0] s_tdest = '0;
  logic [N-1:0] s_tlast = '0, s_tvalid = '0, s_tready;
  logic [63:0] m_tdata;
  logic [1:0] m_tdest;
  logic [IDW-1:0] m_tid;
  logic m_tlast, m_tvalid;
  logic m_tready = 1'b1;
  logic [N-1:0] grant_onehot;
  logic busy;
  always #5 clk = ~clk;
  bsc_ompss_axis_packet_arbiter #(.N_PORTS(N), .ID_WIDTH(IDW), .ID_BASE(IDB)) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tdest(s_tdest), .S_AXIS_tlast(s_tlast),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tdest(m_tdest), .M_AXIS_tid(m_tid),
    .M_AXIS_tlast(m_tlast), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
    .grant_onehot(grant_onehot), .busy(busy)
  );
  typedef struct packed {logic [63:0] d; logic [1:0] dest; logic last;} beat_t;
  typedef struct {int port; logic [63:0] d; int c;} out_t;
  beat_t q[N][$];
  bit en[N];
  int checks = 0, failures = 0, cyc = 0;
  bit m_busy = 1'b0;
  int m_g = 0, m_last = N - 1;
  int glog[$];
  out_t olog[$];
  logic [N-1:0] prev_grant = '0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic push_pkt(int k, int len, logic [63:0] base);
    for (int i = 0; i < len; i++) q[k].push_back({base + 64'(i), 2'(i + k), i == len - 1});
  endtask
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      s_tvalid[k] = en[k] && q[k].size() > 0;
      if (s_tvalid[k]) begin
        s_tdata[64*k +: 64] = q[k][0].d;
        s_tdest[2*k +: 2] = q[k][0].dest;
        s_tlast[k] = q[k][0].last;
      end else begin
        s_tdata[64*k +: 64] = {$urandom, $urandom};
        s_tdest[2*k +: 2] = 2'($urandom);
        s_tlast[k] = 1'($urandom);
      end
    end
  endtask
  task automatic cycle();
    logic [N-1:0] hs, exp_rdy;
    bit ev, lastb;
    drive();
    @(negedge clk);
    ev = m_busy && !rst && s_tvalid[m_g];
    exp_rdy = (m_busy && !rst && m_tready) ? N'(1) << m_g : '0;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("grant_onehot", 64'(grant_onehot), m_busy ? 64'(1) << m_g : 64'(0));
    chk("m_tvalid", 64'(m_tvalid), 64'(ev));
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));
    if (ev) begin
      chk("m_tdata", m_tdata, q[m_g][0].d);
      chk("m_tdest", 64'(m_tdest), 64'(q[m_g][0].dest));
      chk("m_tlast", 64'(m_tlast), 64'(q[m_g][0].last));
      chk("m_tid", 64'(m_tid), 64'(IDB + m_g));
    end
    if (!m_busy) chk("idle_tdata", m_tdata, 64'(0));
    if (grant_onehot != 0 && prev_grant == 0)
      for (int k = 0; k < N; k++) if (grant_onehot[k]) glog.push_back(k);
    prev_grant = grant_onehot;
    if (m_tvalid && m_tready) olog.push_back('{int'(m_tid) - IDB, m_tdata, cyc});
    hs = s_tvalid & s_tready;
    lastb = ev && m_tready && q[m_g][0].last;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) if (hs[k] && q[k].size() > 0) void'(q[k].pop_front());
    if (rst) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else if (!m_busy) begin
      for (int i = 1; i <= N; i++)
        if (!m_busy && s_tvalid[(m_last + i) % N]) begin
          m_busy = 1'b1;
          m_g = (m_last + i) % N;
        end
    end else if (lastb) begin
      m_busy = 1'b0;
      m_last = m_g;
    end
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    m_tready = 1'b1;
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      en[k] = 1'b0;
    end
    run(2);
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_grant", 64'(grant_onehot), 64'(0));
    glog.delete();
    olog.delete();
  endtask
  initial begin
    bit rdy_pat[7] = '{1, 1, 0, 0, 1, 1, 1};
    int ports5[5] = '{0, 0, 0, 0, 3};
    int offs4[3] = '{0, 3, 4};
    // single port, three beats
    do_reset();
    push_pkt(2, 3, 64'hA0);
    en[2] = 1'b1;
    cycle();
    chk("t1_grant", 64'(grant_onehot), 64'b0100);
    run(5);
    chk("t1_beats", 64'(olog.size()), 64'd3);
    for (int i = 0; i < 3 && i < olog.size(); i++) begin
      chk("t1_data", olog[i].d, 64'hA0 + 64'(i));
      chk("t1_tid", 64'(olog[i].port), 64'd2);
      chk("t1_cyc", 64'(olog[i].c - olog[0].c), 64'(i));
    end
    chk("t1_idle", 64'(busy), 64'd0);
    // fairness with all ports valid
    do_reset();
    for (int k = 0; k < N; k++) begin
      push_pkt(k, 2, 64'(16 * k));
      en[k] = 1'b1;
    end
    push_pkt(0, 2, 64'h100);
    run(20);
    chk("t2_ngrant", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("t2_order", 64'(glog[i]), 64'(i % N));
    chk("t2_nbeats", 64'(olog.size()), 64'd10);
    for (int i = 0; i < olog.size(); i++) chk("t2_bubble", 64'(olog[i].c - olog[0].c), 64'(i + i / 2));
    // downstream backpressure pattern
    do_reset();
    push_pkt(1, 3, 64'h10);
    en[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      m_tready = rdy_pat[i];
      cycle();
    end
    m_tready = 1'b1;
    chk("t3_nbeats", 64'(olog.size()), 64'd3);
    for (int i = 0; i < 3 && i < olog.size(); i++) begin
      chk("t3_data", olog[i].d, 64'h10 + 64'(i));
      chk("t3_cyc", 64'(olog[i].c - olog[0].c), 64'(offs4[i]));
    end
    // granted source stalls mid-packet
    do_reset();
    push_pkt(0, 4, 64'h00);
    push_pkt(3, 1, 64'h30);
    en[0] = 1'b1;
    en[3] = 1'b1;
    run(3);
    en[0] = 1'b0;
    run(5);
    en[0] = 1'b1;
    run(8);
    chk("t4_nbeats", 64'(olog.size()), 64'd5);
    for (int i = 0; i < 5 && i < olog.size(); i++) chk("t4_port", 64'(olog[i].port), 64'(ports5[i]));
    chk("t4_ngrant", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) chk("t4_second", 64'(glog[1]), 64'd3);
    // reset during a packet
    do_reset();
    push_pkt(2, 4, 64'h20);
    en[2] = 1'b1;
    run(2);
    push_pkt(0, 1, 64'h01);
    en[0] = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_grant0", 64'(grant_onehot), 64'd0);
    chk("t5_beats", 64'(olog.size()), 64'd1);
    cycle();
    chk("t5_regrant", 64'(grant_onehot), 64'b0001);
    run(10);
    // simultaneous single-beat packets
    do_reset();
    push_pkt(1, 1, 64'h11);
    push_pkt(3, 1, 64'h33);
    en[1] = 1'b1;
    en[3] = 1'b1;
    run(6);
    chk("t6_nbeats", 64'(olog.size()), 64'd2);
    if (olog.size() == 2) begin
      chk("t6_first", 64'(olog[0].port), 64'd1);
      chk("t6_second", 64'(olog[1].port), 64'd3);
      chk("t6_gap", 64'(olog[1].c - olog[0].c), 64'd2);
    end
    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      m_tready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 299) == 0;
      for (int k = 0; k < N; k++) begin
        if (q[k].size() < 4 && $urandom_range(0, 7) == 0) push_pkt(k, $urandom_range(1, 5), {$urandom, $urandom});
        en[k] = $urandom_range(0, 4) != 0;
      end
      cycle();
    end
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
